// File: rtl/bin2bcd_pkg.sv
// Shared types and parameter helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Decimal digits needed to hold 2**width-1: ceil(width * log10(2)).
    // log10(2) is approximated as 30103/100000. 2**width is never a power of ten,
    // so the ceiling is exact for any practical width.
    function automatic int unsigned min_digits(input int unsigned width);
        longint unsigned scaled;
        scaled = longint'(width) * 64'd30103;
        return int'((scaled + 64'd99999) / 64'd100000);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble corrector: adds 3 to a BCD digit of 5 or more before the shift.
// The input never exceeds 9, so the result is at most 12 and fits in 4 bits.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add 3 when the digit would reach 10 or more after doubling
    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Converts one input bit per
// clock. A start/done handshake brackets each conversion.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SW = 4 * DIGITS;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     bin_sr_q;
    logic [SW-1:0]        scratch_q;
    logic [SW-1:0]        scratch_adj;
    logic [SW+WIDTH-1:0]  shift_next;
    logic [CW-1:0]        count_q;
    logic [SW-1:0]        bcd_q;
    logic                 done_q;
    logic                 last_bit;

    // Per-digit correctors act on the pre-shift scratch value
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_q[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    assign last_bit = (count_q == CW'(WIDTH - 1));

    // Corrected digits plus remaining binary bits shifted left as one word
    always_comb begin
        shift_next = {scratch_adj, bin_sr_q} << 1;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: load on accepted start, shift while converting, publish on DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_sr_q  <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_sr_q  <= bin;
                        scratch_q <= '0;
                        count_q   <= '0;
                    end
                end
                SHIFT: begin
                    {scratch_q, bin_sr_q} <= shift_next;
                    if (!last_bit) count_q <= count_q + 1'b1;
                end
                DONE:    bcd_q <= scratch_q;
                default: ;
            endcase
        end
    end

    // done is registered so it rises together with the new bcd value
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
        end
    end

    // Catch a DIGITS value too small to hold the largest input
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (DIGITS >= min_digits(WIDTH))
            else $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == SHIFT);
    assign done  = done_q;
    assign bcd   = bcd_q;

endmodule
